// File: rtl/rob_commit_if.sv
// Decode / write-back / commit / register-status signals of the reorder buffer.
// The slave modport is the ROB controller; the master side is the surrounding pipeline.
interface rob_commit_if #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
);
    logic              alloc_req;
    logic [4:0]        alloc_dest;
    logic              alloc_ready;
    logic [TAG_W-1:0]  alloc_tag;
    logic              wb_valid;
    logic [TAG_W-1:0]  wb_tag;
    logic [DATA_W-1:0] wb_data;
    logic              commit_valid;
    logic [TAG_W-1:0]  commit_tag;
    logic [4:0]        commit_dest;
    logic [DATA_W-1:0] commit_data;
    logic              rs_clear;
    logic [4:0]        rs_regclear;
    logic [TAG_W-1:0]  rs_check_index;
    logic              flush;
    logic [TAG_W-1:0]  count;

    modport slave (
        input  alloc_req, alloc_dest, wb_valid, wb_tag, wb_data, rs_check_index, flush,
        output alloc_ready, alloc_tag, commit_valid, commit_tag, commit_dest, commit_data,
               rs_clear, rs_regclear, count
    );

    modport master (
        output alloc_req, alloc_dest, wb_valid, wb_tag, wb_data, rs_check_index, flush,
        input  alloc_ready, alloc_tag, commit_valid, commit_tag, commit_dest, commit_data,
               rs_clear, rs_regclear, count
    );
endinterface

// File: rtl/rob_commit_ctrl.sv
// In-order reorder-buffer controller: issues tags 1..NUM_TAGS, records write-back,
// retires in program order and gates the register-status clear on tag ownership.
module rob_commit_ctrl #(
    parameter int NUM_TAGS = 15,
    parameter int TAG_W    = 4,
    parameter int DATA_W   = 32
) (
    input  logic         clk,
    input  logic         rst,
    rob_commit_if.slave  rob
);
    logic [TAG_W-1:0]  head_reg, tail_reg, count_reg;
    logic [TAG_W-1:0]  head_next, tail_next, count_next;
    logic [NUM_TAGS:1] valid_reg, done_reg;
    logic [NUM_TAGS:1] valid_next, done_next;
    logic [4:0]        dest_mem [1:NUM_TAGS];
    logic [DATA_W-1:0] data_mem [1:NUM_TAGS];

    logic accept;
    logic commit;
    logic wb_ok;

    // Tag 0 means "in the register file", so pointers wrap NUM_TAGS -> 1.
    function automatic logic [TAG_W-1:0] wrap_inc(input logic [TAG_W-1:0] p);
        return (p == TAG_W'(NUM_TAGS)) ? TAG_W'(1) : p + TAG_W'(1);
    endfunction

    assign rob.alloc_ready  = (count_reg < TAG_W'(NUM_TAGS)) && !rob.flush;
    assign rob.alloc_tag    = tail_reg;
    assign rob.commit_valid = valid_reg[head_reg] && done_reg[head_reg] && !rob.flush;
    assign rob.commit_tag   = head_reg;
    assign rob.commit_dest  = dest_mem[head_reg];
    assign rob.commit_data  = data_mem[head_reg];
    assign rob.rs_regclear  = dest_mem[head_reg];
    // A younger producer that re-mapped the register owns the status entry; leave it alone.
    assign rob.rs_clear     = rob.commit_valid && (rob.commit_dest != 5'd0) &&
                              (rob.rs_check_index == head_reg);
    assign rob.count        = count_reg;

    assign accept = rob.alloc_req && rob.alloc_ready;
    assign commit = rob.commit_valid;
    assign wb_ok  = rob.wb_valid && !rob.flush && (rob.wb_tag != '0) && valid_reg[rob.wb_tag];

    genvar gi;
    generate
        for (gi = 1; gi <= NUM_TAGS; gi++) begin : g_entry
            logic alloc_hit, wb_hit, commit_hit;
            assign alloc_hit  = accept && (tail_reg == TAG_W'(gi));
            assign wb_hit     = wb_ok  && (rob.wb_tag == TAG_W'(gi));
            assign commit_hit = commit && (head_reg == TAG_W'(gi));

            // Retirement wins over a late write-back to the same entry.
            assign valid_next[gi] = rob.flush  ? 1'b0 :
                                    commit_hit ? 1'b0 :
                                    alloc_hit  ? 1'b1 : valid_reg[gi];
            assign done_next[gi]  = rob.flush  ? 1'b0 :
                                    commit_hit ? 1'b0 :
                                    alloc_hit  ? 1'b0 :
                                    wb_hit     ? 1'b1 : done_reg[gi];
        end
    endgenerate

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (rob.flush) begin
            head_next  = TAG_W'(1);
            tail_next  = TAG_W'(1);
            count_next = '0;
        end else begin
            if (commit) head_next = wrap_inc(head_reg);
            if (accept) tail_next = wrap_inc(tail_reg);
            case ({accept, commit})
                2'b10:   count_next = count_reg + TAG_W'(1);
                2'b01:   count_next = count_reg - TAG_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg  <= TAG_W'(1);
            tail_reg  <= TAG_W'(1);
            count_reg <= '0;
            valid_reg <= '0;
            done_reg  <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
            valid_reg <= valid_next;
            done_reg  <= done_next;
        end
    end

    // Payload storage needs no reset: it is only observed behind valid/done.
    always_ff @(posedge clk) begin
        if (accept) dest_mem[tail_reg]   <= rob.alloc_dest;
        if (wb_ok)  data_mem[rob.wb_tag] <= rob.wb_data;
    end
endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Bench for rob_commit_ctrl: program-order queue model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rob_commit_ctrl;
    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    rob_commit_if #(.TAG_W(4), .DATA_W(32)) bus ();

    rob_commit_ctrl #(.NUM_TAGS(15), .TAG_W(4), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .rob (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  tag;
        logic [4:0]  dest;
        bit          done;
        logic [31:0] data;
    } ent_t;

    ent_t       q[$];
    logic [3:0] m_head = 4'd1;
    logic [3:0] m_tail = 4'd1;

    function automatic logic [3:0] nxt(input logic [3:0] t);
        return (t == 4'd15) ? 4'd1 : t + 4'd1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the in-flight entries are simply a program-order queue.
    always @(negedge clk) begin
        bit e_ready, e_commit, e_clear, acc;
        int n;
        if (rst) begin
            q.delete();
            m_head = 4'd1;
            m_tail = 4'd1;
        end
        n        = q.size();
        e_ready  = (n < 15) && !bus.flush;
        e_commit = 1'b0;
        e_clear  = 1'b0;
        if (n > 0) begin
            e_commit = q[0].done && !bus.flush;
            e_clear  = e_commit && (q[0].dest != 5'd0) && (bus.rs_check_index == q[0].tag);
        end
        chk("alloc_ready",  {31'd0, bus.alloc_ready},  {31'd0, e_ready});
        chk("alloc_tag",    {28'd0, bus.alloc_tag},    {28'd0, m_tail});
        chk("count",        {28'd0, bus.count},        n);
        chk("commit_valid", {31'd0, bus.commit_valid}, {31'd0, e_commit});
        chk("rs_clear",     {31'd0, bus.rs_clear},     {31'd0, e_clear});
        if (n > 0) chk("rs_regclear", {27'd0, bus.rs_regclear}, {27'd0, q[0].dest});
        if (e_commit) begin
            chk("commit_tag",  {28'd0, bus.commit_tag},  {28'd0, q[0].tag});
            chk("commit_dest", {27'd0, bus.commit_dest}, {27'd0, q[0].dest});
            chk("commit_data", bus.commit_data,          q[0].data);
        end
        if (!rst) begin
            if (bus.flush) begin
                q.delete();
                m_head = 4'd1;
                m_tail = 4'd1;
            end else begin
                acc = bus.alloc_req && e_ready;
                if (e_commit) begin
                    void'(q.pop_front());
                    m_head = nxt(m_head);
                end
                if (bus.wb_valid)
                    foreach (q[i])
                        if (q[i].tag == bus.wb_tag) begin
                            q[i].done = 1'b1;
                            q[i].data = bus.wb_data;
                        end
                if (acc) begin
                    q.push_back('{m_tail, bus.alloc_dest, 1'b0, 32'd0});
                    m_tail = nxt(m_tail);
                end
            end
        end
    end

    task automatic drive(input bit req, input logic [4:0] d, input bit wv, input logic [3:0] wt,
                         input logic [31:0] wd, input logic [3:0] ci, input bit fl);
        bus.alloc_req      = req;
        bus.alloc_dest     = d;
        bus.wb_valid       = wv;
        bus.wb_tag         = wt;
        bus.wb_data        = wd;
        bus.rs_check_index = ci;
        bus.flush          = fl;
    endtask

    task automatic idle();
        drive(0, 5'd0, 0, 4'd0, 32'd0, 4'd0, 0);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        settle();
        $display("reset state");
        chk("rst_alloc_ready",  {31'd0, bus.alloc_ready},  32'd1);
        chk("rst_alloc_tag",    {28'd0, bus.alloc_tag},    32'd1);
        chk("rst_count",        {28'd0, bus.count},        32'd0);
        chk("rst_commit_valid", {31'd0, bus.commit_valid}, 32'd0);
        chk("rst_rs_clear",     {31'd0, bus.rs_clear},     32'd0);
        adv();
        rst = 1'b0;

        $display("in-order retire with out-of-order write-back");
        drive(1, 5'd3, 0, 4'd0, 32'd0, 4'd0, 0); settle();
        chk("t1_tag_a", {28'd0, bus.alloc_tag}, 32'd1); adv();
        drive(1, 5'd4, 0, 4'd0, 32'd0, 4'd0, 0); settle();
        chk("t1_tag_b", {28'd0, bus.alloc_tag}, 32'd2); adv();
        drive(0, 5'd0, 1, 4'd2, 32'hBBBB, 4'd0, 0); settle();
        chk("t1_count2", {28'd0, bus.count}, 32'd2);
        chk("t1_no_commit_a", {31'd0, bus.commit_valid}, 32'd0); adv();
        drive(0, 5'd0, 1, 4'd1, 32'hAAAA, 4'd0, 0); settle();
        chk("t1_no_bypass", {31'd0, bus.commit_valid}, 32'd0); adv();
        idle(); settle();
        chk("t1_commit1_v",    {31'd0, bus.commit_valid}, 32'd1);
        chk("t1_commit1_tag",  {28'd0, bus.commit_tag},   32'd1);
        chk("t1_commit1_dest", {27'd0, bus.commit_dest},  32'd3);
        chk("t1_commit1_data", bus.commit_data,           32'hAAAA); adv();
        settle();
        chk("t1_commit2_tag",  {28'd0, bus.commit_tag},   32'd2);
        chk("t1_commit2_data", bus.commit_data,           32'hBBBB); adv();
        settle();
        chk("t1_empty", {28'd0, bus.count}, 32'd0); adv();
        drive(1, 5'd0, 0, 4'd0, 32'd0, 4'd0, 1); settle();
        chk("flush_ready", {31'd0, bus.alloc_ready}, 32'd0); adv();
        idle(); settle();
        chk("flush_tag1", {28'd0, bus.alloc_tag}, 32'd1); adv();

        $display("fill to full and wrap");
        for (int i = 0; i < 15; i++) begin
            drive(1, 5'(i + 1), 0, 4'd0, 32'd0, 4'd0, 0);
            adv();
        end
        drive(1, 5'd9, 1, 4'd1, 32'h1111, 4'd0, 0); settle();
        chk("t2_full_count", {28'd0, bus.count},       32'd15);
        chk("t2_full_ready", {31'd0, bus.alloc_ready}, 32'd0); adv();
        drive(1, 5'd9, 0, 4'd0, 32'd0, 4'd0, 0); settle();
        chk("t2_commit_full", {31'd0, bus.commit_valid}, 32'd1);
        chk("t2_no_bypass",   {31'd0, bus.alloc_ready},  32'd0); adv();
        settle();
        chk("t2_wrap_tag",   {28'd0, bus.alloc_tag},   32'd1);
        chk("t2_wrap_ready", {31'd0, bus.alloc_ready}, 32'd1); adv();
        idle(); settle();
        chk("t2_refull", {28'd0, bus.count}, 32'd15); adv();
        drive(0, 5'd0, 0, 4'd0, 32'd0, 4'd0, 1); adv();

        $display("register-status ownership");
        drive(1, 5'd5, 0, 4'd0, 32'd0, 4'd0, 0); adv();
        drive(1, 5'd5, 0, 4'd0, 32'd0, 4'd0, 0); adv();
        drive(0, 5'd0, 1, 4'd2, 32'h22, 4'd0, 0); adv();
        drive(0, 5'd0, 1, 4'd1, 32'h11, 4'd0, 0); adv();
        drive(0, 5'd0, 0, 4'd0, 32'd0, 4'd2, 0); settle();
        chk("t3_old_commit", {31'd0, bus.commit_valid}, 32'd1);
        chk("t3_old_noclr",  {31'd0, bus.rs_clear},     32'd0);
        chk("t3_old_reg",    {27'd0, bus.rs_regclear},  32'd5); adv();
        settle();
        chk("t3_new_clr", {31'd0, bus.rs_clear},    32'd1);
        chk("t3_new_reg", {27'd0, bus.rs_regclear}, 32'd5); adv();
        drive(1, 5'd0, 0, 4'd0, 32'd0, 4'd0, 0); adv();
        drive(0, 5'd0, 1, 4'd3, 32'h33, 4'd0, 0); adv();
        drive(0, 5'd0, 0, 4'd0, 32'd0, 4'd3, 0); settle();
        chk("t4_dest0_commit", {31'd0, bus.commit_valid}, 32'd1);
        chk("t4_dest0_noclr",  {31'd0, bus.rs_clear},     32'd0); adv();

        $display("ignored write-backs");
        drive(0, 5'd0, 1, 4'd0, 32'hDEAD, 4'd0, 0); adv();
        drive(0, 5'd0, 1, 4'd7, 32'hBEEF, 4'd0, 0); adv();
        idle(); settle();
        chk("t5_no_commit", {31'd0, bus.commit_valid}, 32'd0);
        chk("t5_count0",    {28'd0, bus.count},        32'd0); adv();
        for (int i = 0; i < 4; i++) begin
            drive(1, 5'(i + 10), 0, 4'd0, 32'd0, 4'd0, 0);
            adv();
        end
        idle(); adv(); adv();
        drive(0, 5'd0, 0, 4'd0, 32'd0, 4'd0, 1); adv();

        $display("flush with entries in flight");
        for (int i = 0; i < 6; i++) begin
            drive(1, 5'(i + 20), 0, 4'd0, 32'd0, 4'd0, 0);
            adv();
        end
        drive(0, 5'd0, 1, 4'd2, 32'h2, 4'd0, 0); adv();
        drive(0, 5'd0, 1, 4'd1, 32'h1, 4'd0, 0); adv();
        drive(1, 5'd7, 0, 4'd0, 32'd0, 4'd0, 1); settle();
        chk("t6_flush_nocommit", {31'd0, bus.commit_valid}, 32'd0); adv();
        idle(); settle();
        chk("t6_count0", {28'd0, bus.count},     32'd0);
        chk("t6_tag1",   {28'd0, bus.alloc_tag}, 32'd1); adv();
        drive(0, 5'd0, 1, 4'd1, 32'h99, 4'd0, 0); adv();
        drive(1, 5'd8, 0, 4'd0, 32'd0, 4'd0, 0); adv();
        idle(); settle();
        chk("t6_stale_wb", {31'd0, bus.commit_valid}, 32'd0); adv();
        drive(0, 5'd0, 0, 4'd0, 32'd0, 4'd0, 1); adv();

        $display("randomized traffic");
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] wt;
            logic [3:0] ci;
            if (q.size() > 0 && ($urandom % 4) != 0)
                wt = q[$urandom % q.size()].tag;
            else
                wt = 4'($urandom_range(0, 15));
            ci = ($urandom % 2 == 0) ? m_head : 4'($urandom_range(0, 15));
            drive(($urandom % 10) < 6, 5'($urandom_range(0, 31)), ($urandom % 2) == 1, wt,
                  $urandom, ci, ($urandom % 60) == 0);
            rst = (($urandom % 300) == 0);
            adv();
        end
        rst = 1'b0;
        idle();
        adv();
        settle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
